// File: rtl/div_pkg.sv
// Shared constants, FSM state and result types for the sequential signed divider.
package div_pkg;
  localparam int DW    = 16;
  localparam int VW    = 8;
  localparam int ITERS = 16;
  localparam int CW    = 4;

  localparam logic [VW-1:0] QSAT_POS = 8'h7F;
  localparam logic [VW-1:0] QSAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  typedef struct packed {
    logic [VW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dz;
    logic          ovf;
  } res_t;

  // Two's-complement magnitude; the most negative value maps to its unsigned bit pattern.
  function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [VW-1:0] abs_vw(input logic [VW-1:0] x);
    return x[VW-1] ? (~x + 1'b1) : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [VW:0]   pr,
  input  logic          din,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   pr_nxt,
  output logic          qbit
);
  logic [VW:0] sh;

  // pr is always below |divisor| <= 128 entering a step, so its top bit can be dropped.
  assign sh     = {pr[VW-1:0], din};
  assign qbit   = (sh >= {1'b0, dvs});
  assign pr_nxt = qbit ? (sh - {1'b0, dvs}) : sh;
endmodule

// File: rtl/signed_seq_divider.sv
// 16/8 signed sequential divider: 16 restoring iterations on magnitudes, then sign fix-up.
module signed_seq_divider
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [VW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz,
  output logic          ovf
);
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW:0]   pr, pr_nxt;
  logic          qbit;
  logic          sign_q, sign_r;
  logic          done_r;
  res_t          res, fix_res;

  div_step u_step (
    .pr     (pr),
    .din    (dvd[DW-1]),
    .dvs    (dvs),
    .pr_nxt (pr_nxt),
    .qbit   (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(ITERS-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // After 16 steps dvd holds the magnitude quotient and pr the magnitude remainder.
  always_comb begin
    fix_res = '0;
    if (dvs == '0) begin
      fix_res.dz = 1'b1;
    end else if ((!sign_q && dvd > DW'(127)) || (sign_q && dvd > DW'(128))) begin
      fix_res.ovf      = 1'b1;
      fix_res.quotient = sign_q ? QSAT_NEG : QSAT_POS;
    end else begin
      fix_res.quotient  = sign_q ? (~dvd[VW-1:0] + 1'b1) : dvd[VW-1:0];
      fix_res.remainder = sign_r ? (~pr[VW-1:0] + 1'b1) : pr[VW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      pr     <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      done_r <= 1'b0;
      res    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            sign_q <= dividend[DW-1] ^ divisor[VW-1];
            sign_r <= dividend[DW-1];
            dvd    <= abs_dw(dividend);
            dvs    <= abs_vw(divisor);
            pr     <= '0;
          end
        end
        CALC: begin
          dvd <= {dvd[DW-2:0], qbit};
          pr  <= pr_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          res    <= fix_res;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign quotient  = res.quotient;
  assign remainder = res.remainder;
  assign dz        = res.dz;
  assign ovf       = res.ovf;
endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed bench for signed_seq_divider with hand-computed results.
module tb_signed_seq_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, dz, ovf;
  logic [7:0]  quotient, remainder;

  int checks = 0;
  int failures = 0;
  int lat;

  signed_seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'h5A5A;
    divisor  = 8'h03;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_low_after_accept", 32'(done), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic check_res(input string tag, input logic [7:0] eq, input logic [7:0] er,
                           input logic edz, input logic eovf);
    chk({tag, "_q"},   32'(quotient),  32'(eq));
    chk({tag, "_r"},   32'(remainder), 32'(er));
    chk({tag, "_dz"},  32'(dz),        32'(edz));
    chk({tag, "_ovf"}, 32'(ovf),       32'(eovf));
    chk({tag, "_busy"}, 32'(busy),     32'd0);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz, input logic eovf);
    launch(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd17);
    check_res(tag, eq, er, edz, eovf);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("p100_7",    16'd100,    8'd7,    8'h0E, 8'h02, 1'b0, 1'b0);
    do_op("m100_7",    -16'sd100,  8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0);
    do_op("p100_m7",   16'd100,    -8'sd7,  8'hF2, 8'h02, 1'b0, 1'b0);
    do_op("p16384_m128", 16'd16384, 8'h80,  8'h80, 8'h00, 1'b0, 1'b0);
    do_op("m16384_m128", 16'hC000,  8'h80,  8'h7F, 8'h00, 1'b0, 1'b1);
    do_op("p1000_3",   16'd1000,   8'd3,    8'h7F, 8'h00, 1'b0, 1'b1);
    do_op("p1234_0",   16'd1234,   8'd0,    8'h00, 8'h00, 1'b1, 1'b0);
    do_op("m1001_8",   -16'sd1001, 8'd8,    8'h83, 8'hFF, 1'b0, 1'b0);
    do_op("m1032_8",   -16'sd1032, 8'd8,    8'h80, 8'h00, 1'b0, 1'b1);
    do_op("p1016_m8",  16'd1016,   -8'sd8,  8'h81, 8'h00, 1'b0, 1'b0);
    do_op("m32768_m1", 16'h8000,   8'hFF,   8'h7F, 8'h00, 1'b0, 1'b1);
    do_op("m128_m128", -16'sd128,  8'h80,   8'h01, 8'h00, 1'b0, 1'b0);

    // Start while busy is ignored
    launch(16'd100, 8'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd12);
    check_res("ign", 8'h0E, 8'h02, 1'b0, 1'b0);

    // Back-to-back start in the done cycle
    launch(-16'sd100, 8'd7);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd17);
    check_res("b2b", 8'hF2, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);

    // Reset mid-calculation aborts
    launch(16'd1000, 8'd9);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    do_op("post_rst", 16'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
